// File: rtl/tiny_dnn_pkg.sv
// Shared definitions for the tiny_dnn stream adapters.
//   DST_W      : width of one accelerator result word
//   AXIS_W     : width of the packed AXI4-Stream data bus
//   dst_entry_t: one buffered beat, packed data plus its computed last flag
package tiny_dnn_pkg;

  localparam int unsigned DST_W  = 32;
  localparam int unsigned AXIS_W = 64;

  typedef struct packed {
    logic              last;
    logic [AXIS_W-1:0] data;
  } dst_entry_t;

endpackage

// File: rtl/tiny_dnn_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush, dominates push and pop
//   push/wdata : write strobe and data (ignored when full)
//   pop/rdata  : read strobe (ignored when empty); rdata shows the head entry
//   level      : number of valid entries, full/empty decoded from it
module tiny_dnn_sync_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Pointers are AW bits wide with DEPTH a power of two, so they wrap naturally.
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/tiny_dnn_dst_axis.sv
// Accelerator dst stream to 64-bit AXI4-Stream adapter.
//   clr, run, len          : flush, run level, programmed beats per frame (0 = use dst_last)
//   dst_*                  : upstream valid/ready stream, two words per beat plus dst_last
//   m_axis_*               : downstream AXI4-Stream, tdata = {dst_data1, dst_data0}
//   frame_cnt, err_len     : frames emitted (wrapping), sticky dst_last/len mismatch
//   level                  : FIFO occupancy
module tiny_dnn_dst_axis
  import tiny_dnn_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LEN_W  = 12,
  parameter int unsigned FCNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     run,
  input  logic [LEN_W-1:0]         len,
  input  logic                     dst_valid,
  input  logic [DST_W-1:0]         dst_data0,
  input  logic [DST_W-1:0]         dst_data1,
  input  logic                     dst_last,
  output logic                     dst_ready,
  output logic                     m_axis_tvalid,
  output logic [AXIS_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic [FCNT_W-1:0]        frame_cnt,
  output logic                     err_len,
  output logic [$clog2(DEPTH):0]   level
);

  dst_entry_t          wr_entry, rd_entry;
  logic                fifo_full, fifo_empty;
  logic                push, pop, calc_last;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                err_len_q, err_len_d;

  // Ready comes only from registered occupancy, never from m_axis_tready.
  assign dst_ready     = ~fifo_full;
  assign m_axis_tvalid = ~fifo_empty;
  assign push          = dst_valid & dst_ready;
  assign pop           = m_axis_tvalid & m_axis_tready;

  assign calc_last     = (len != '0) ? (beat_cnt_q == len - LEN_W'(1)) : dst_last;
  assign wr_entry.last = calc_last;
  assign wr_entry.data = {dst_data1, dst_data0};

  tiny_dnn_sync_fifo #(
    .WIDTH ($bits(dst_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_axis_tdata = rd_entry.data;
  assign m_axis_tlast = rd_entry.last;
  assign frame_cnt    = frame_cnt_q;
  assign err_len      = err_len_q;

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_len_d   = err_len_q;
    if (clr) begin
      beat_cnt_d = '0;
      err_len_d  = 1'b0;
    end else begin
      if (!run) begin
        beat_cnt_d = '0;
      end else if (push) begin
        if (len == '0 || calc_last) beat_cnt_d = '0;
        else                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
      end
      if (push && (len != '0) && (dst_last != calc_last)) err_len_d = 1'b1;
      if (pop && m_axis_tlast) frame_cnt_d = frame_cnt_q + FCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
      err_len_q   <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_len_q   <= err_len_d;
    end
  end

endmodule

// File: tb/tb_tiny_dnn_dst_axis.sv
module tb_tiny_dnn_dst_axis;

  localparam int DEPTH  = 4;
  localparam int LEN_W  = 12;
  localparam int FCNT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n, clr, run;
  logic [LEN_W-1:0]  len;
  logic              dst_valid, dst_last, dst_ready;
  logic [31:0]       dst_data0, dst_data1;
  logic              m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [63:0]       m_axis_tdata;
  logic [FCNT_W-1:0] frame_cnt;
  logic              err_len;
  logic [2:0]        level;

  int checks = 0;
  int errors = 0;

  // Reference model: expected beats in push order, observed beats in pop order.
  logic [64:0] exp_q[$];
  logic [64:0] got_q[$];
  int unsigned model_k;     // beats pushed since the count was last restarted
  logic        model_err;
  int unsigned max_level;

  always #5 clk = ~clk;

  tiny_dnn_dst_axis #(.DEPTH(DEPTH), .LEN_W(LEN_W), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .run(run), .len(len),
    .dst_valid(dst_valid), .dst_data0(dst_data0), .dst_data1(dst_data1),
    .dst_last(dst_last), .dst_ready(dst_ready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .frame_cnt(frame_cnt), .err_len(err_len), .level(level)
  );

  // One clock of stimulus, called with clk low; records handshakes into the model.
  task automatic drive_cycle(input logic v, input logic [31:0] d0, input logic [31:0] d1,
                             input logic last, input logic rdy, output logic pushed);
    logic el;
    dst_valid = v; dst_data0 = d0; dst_data1 = d1; dst_last = last; m_axis_tready = rdy;
    #1;
    pushed = v && dst_ready;
    if (pushed) begin
      if (len == 0) el = last;
      else begin
        el = ((model_k % len) == (len - 1));
        model_k++;
        if (last !== el) model_err = 1'b1;
      end
      exp_q.push_back({el, d1, d0});
    end
    if (m_axis_tvalid && rdy) got_q.push_back({m_axis_tlast, m_axis_tdata});
    if (level > max_level) max_level = level;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int bound);
    logic p;
    int n = 0;
    while ((got_q.size() < exp_q.size() || m_axis_tvalid) && n < bound) begin
      drive_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, p);
      n++;
    end
    if (n >= bound) begin
      checks++; errors++;
      $display("FAIL %s_drain_timeout got %0d beats required %0d", name, got_q.size(), exp_q.size());
    end
  endtask

  task automatic do_clr();
    clr = 1'b1; dst_valid = 1'b0; m_axis_tready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    exp_q.delete(); got_q.delete();
    model_k = 0; model_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; run = 1'b1; len = '0;
    dst_valid = 1'b0; dst_data0 = '0; dst_data1 = '0; dst_last = 1'b0; m_axis_tready = 1'b0;
    #1;
    checks++; if (level !== 3'd0)         begin errors++; $display("FAIL reset_level got %0d required 0", level); end
    checks++; if (dst_ready !== 1'b1)     begin errors++; $display("FAIL reset_ready got %b required 1", dst_ready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b required 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 64'd0) begin errors++; $display("FAIL reset_tdata got %h required 0", m_axis_tdata); end
    checks++; if (m_axis_tlast !== 1'b0)  begin errors++; $display("FAIL reset_tlast got %b required 0", m_axis_tlast); end
    checks++; if (frame_cnt !== 16'd0)    begin errors++; $display("FAIL reset_frame_cnt got %0d required 0", frame_cnt); end
    checks++; if (err_len !== 1'b0)       begin errors++; $display("FAIL reset_err_len got %b required 0", err_len); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete(); got_q.delete(); model_k = 0; model_err = 1'b0; max_level = 0;
  endtask

  task automatic test_basic();
    logic p;
    logic [FCNT_W-1:0] f0;
    do_clr();
    len = 12'd4; f0 = frame_cnt;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, $urandom, $urandom, (i == 3 || i == 7), 1'b1, p);
      if (i == 0) begin
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL basic_latency tvalid got %b required 1", m_axis_tvalid); end
      end
    end
    drain("basic", 50);
    checks++; if (got_q.size() !== 8) begin errors++; $display("FAIL basic_count got %0d required 8", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[i][64] !== (i == 3 || i == 7)) begin errors++; $display("FAIL basic_tlast%0d got %b required %b", i, got_q[i][64], (i == 3 || i == 7)); end
      end
    end
    checks++; if (frame_cnt - f0 !== 16'd2) begin errors++; $display("FAIL basic_frames got %0d required 2", frame_cnt - f0); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL basic_err got %b required 0", err_len); end
  endtask

  task automatic test_backpressure();
    logic p;
    logic [31:0] d0, d1;
    logic [63:0] head0;
    int pushes = 0;
    do_clr();
    len = 12'd4;
    d0 = $urandom; d1 = $urandom;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(1'b1, d0, d1, (pushes == 3), 1'b0, p);
      if (p) begin pushes++; d0 = $urandom; d1 = $urandom; end
      if (c == 0) head0 = m_axis_tdata;
    end
    checks++; if (pushes !== 4)          begin errors++; $display("FAIL bp_pushes got %0d required 4", pushes); end
    checks++; if (level !== 3'd4)        begin errors++; $display("FAIL bp_level got %0d required 4", level); end
    checks++; if (dst_ready !== 1'b0)    begin errors++; $display("FAIL bp_ready got %b required 0", dst_ready); end
    checks++; if (m_axis_tdata !== head0 || head0 !== exp_q[0][63:0])
      begin errors++; $display("FAIL bp_hold got %h required %h", m_axis_tdata, exp_q[0][63:0]); end
    drain("bp", 50);
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL bp_count got %0d required 4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_mismatch();
    logic p;
    do_clr();
    len = 12'd3;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, $urandom, $urandom, (i == 1), 1'b1, p);
    drain("mm", 50);
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL mm_count got %0d required 3", got_q.size()); end
    if (got_q.size() == 3) begin
      checks++; if (got_q[1][64] !== 1'b0) begin errors++; $display("FAIL mm_tlast2 got %b required 0", got_q[1][64]); end
      checks++; if (got_q[2][64] !== 1'b1) begin errors++; $display("FAIL mm_tlast3 got %b required 1", got_q[2][64]); end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mm_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (err_len !== model_err || model_err !== 1'b1) begin errors++; $display("FAIL mm_err got %b required 1", err_len); end
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, p);
    checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL mm_err_sticky got %b required 1", err_len); end
    do_clr();
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL mm_err_clr got %b required 0", err_len); end
  endtask

  task automatic test_passthrough();
    logic p;
    logic [FCNT_W-1:0] f0;
    logic [4:0] pat;
    pat = 5'b10011;
    do_clr();
    len = '0; f0 = frame_cnt;
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, $urandom, $urandom, pat[i], 1'b1, p);
    drain("pt", 50);
    checks++; if (got_q.size() !== 5) begin errors++; $display("FAIL pt_count got %0d required 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_q[i][64] !== pat[i]) begin errors++; $display("FAIL pt_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frame_cnt - f0 !== 16'd3) begin errors++; $display("FAIL pt_frames got %0d required 3", frame_cnt - f0); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL pt_err got %b required 0", err_len); end
  endtask

  task automatic test_run();
    logic p;
    do_clr();
    len = 12'd4;
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, $urandom, $urandom, 1'b0, 1'b1, p);
    run = 1'b0;
    drive_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, p);
    run = 1'b1;
    model_k = 0;   // run low restarts the beat count
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, $urandom, $urandom, (i == 3), 1'b1, p);
    drain("run", 50);
    checks++; if (got_q.size() !== 6) begin errors++; $display("FAIL run_count got %0d required 6", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL run_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL run_err got %b required 0", err_len); end
  endtask

  task automatic test_random();
    logic p;
    logic [31:0] d0, d1;
    logic [FCNT_W-1:0] f0;
    int sent = 0;
    int cyc = 0;
    do_clr();
    len = 12'd7; f0 = frame_cnt; max_level = 0;
    d0 = $urandom; d1 = $urandom;
    while (sent < 1000 && cyc < 20000) begin
      drive_cycle($urandom_range(0, 1), d0, d1, ((sent % 7) == 6), $urandom_range(0, 1), p);
      if (p) begin sent++; d0 = $urandom; d1 = $urandom; end
      cyc++;
    end
    if (cyc >= 20000) begin
      checks++; errors++; $display("FAIL rand_send_timeout got %0d beats required 1000", sent);
    end
    drain("rand", 100);
    checks++; if (got_q.size() !== 1000) begin errors++; $display("FAIL rand_count got %0d required 1000", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (max_level > 4) begin errors++; $display("FAIL rand_max_level got %0d required <=4", max_level); end
    checks++; if (frame_cnt - f0 !== 16'd142) begin errors++; $display("FAIL rand_frames got %0d required 142", frame_cnt - f0); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL rand_err got %b required 0", err_len); end
  endtask

  task automatic test_flush_reset();
    logic p;
    logic [FCNT_W-1:0] f0;
    do_clr();
    len = 12'd4; f0 = frame_cnt;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, p);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL flush_pre_level got %0d required 3", level); end
    clr = 1'b1; dst_valid = 1'b1; dst_data0 = $urandom; dst_data1 = $urandom; dst_last = 1'b0; m_axis_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0; dst_valid = 1'b0;
    exp_q.delete(); got_q.delete(); model_k = 0; model_err = 1'b0;
    checks++; if (level !== 3'd0)         begin errors++; $display("FAIL flush_level got %0d required 0", level); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL flush_tvalid got %b required 0", m_axis_tvalid); end
    checks++; if (frame_cnt !== f0)       begin errors++; $display("FAIL flush_frames got %0d required %0d", frame_cnt, f0); end
    // Queue a mid-frame beat with a wrong dst_last so err_len is set going into reset.
    drive_cycle(1'b1, 32'hdead_beef, 32'h1234_5678, 1'b1, 1'b0, p);
    drive_cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, p);
    rst_n = 1'b0;
    #1;
    checks++; if (level !== 3'd0)         begin errors++; $display("FAIL rst_level got %0d required 0", level); end
    checks++; if (dst_ready !== 1'b1)     begin errors++; $display("FAIL rst_ready got %b required 1", dst_ready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b required 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 64'd0) begin errors++; $display("FAIL rst_tdata got %h required 0", m_axis_tdata); end
    checks++; if (m_axis_tlast !== 1'b0)  begin errors++; $display("FAIL rst_tlast got %b required 0", m_axis_tlast); end
    checks++; if (frame_cnt !== 16'd0)    begin errors++; $display("FAIL rst_frames got %0d required 0", frame_cnt); end
    checks++; if (err_len !== 1'b0)       begin errors++; $display("FAIL rst_err got %b required 0", err_len); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_mismatch();
    test_passthrough();
    test_run();
    test_random();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
